pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the five-stage pipeline. It produces the enable and synchronous-flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It resolves data-memory waits, instruction-fetch misses, load-use hazards, branch/jump squashes and the halt drain. Two saturating performance counters are kept for debug.

---
 rtl/pipeline_ctrl_if.sv | 42 ++++
 rtl/pipeline_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: hazard inputs from the datapath latches and
// the enable/flush controls returned to the PC and pipeline latches.
interface pipeline_ctrl_if;
    logic       ihit;
    logic       dhit;
    logic       mem_dREN;
    logic       mem_dWEN;
    logic       mem_halt;
    logic       wb_halt;
    logic       ex_dREN;
    logic [4:0] ex_wsel;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_branch_taken;
    logic       id_jump;

    logic       pc_en;
    logic       ifid_en;
    logic       idex_en;
    logic       exmem_en;
    logic       memwb_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       memwb_flush;

    // Datapath side: reports hazards, consumes latch controls.
    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, mem_halt, wb_halt,
               ex_dREN, ex_wsel, id_rs, id_rt, ex_branch_taken, id_jump,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush
    );

    // Controller side.
    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, mem_halt, wb_halt,
               ex_dREN, ex_wsel, id_rs, id_rt, ex_branch_taken, id_jump,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline.
// Resolves data waits, fetch misses, load-use hazards, branch/jump
// squashes and the halt drain; keeps two saturating debug counters.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    pipeline_ctrl_if.slave   pif,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] squash_events
);

    typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

    state_t state, next_state;

    logic dreq;
    logic luse;
    logic stall_inc;
    logic squash_inc;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

    assign dreq = pif.mem_dREN | pif.mem_dWEN;
    assign luse = pif.ex_dREN & (pif.ex_wsel != 5'd0) &
                  ((pif.ex_wsel == pif.id_rs) | (pif.ex_wsel == pif.id_rt));

    // State register; reset always returns to RUN so no wait or drain survives.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next state and latch controls; everything is held at zero during reset.
    always_comb begin
        next_state  = state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        stall_inc   = 1'b0;
        squash_inc  = 1'b0;

        if (nRST) begin
            case (state)
                RUN, DWAIT: begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    next_state = RUN;
                    if (dreq && !pif.dhit) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_flush = 1'b1;
                        stall_inc   = 1'b1;
                        next_state  = DWAIT;
                    end else if (pif.mem_halt) begin
                        pc_en       = 1'b0;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        next_state  = DRAIN;
                    end else if (pif.ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        squash_inc = 1'b1;
                    end else if (luse) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (pif.id_jump) begin
                        ifid_flush = 1'b1;
                        squash_inc = 1'b1;
                    end else if (!pif.ihit) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end
                end
                DRAIN: begin
                    ifid_en     = 1'b1;
                    idex_en     = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    stall_inc   = 1'b1;
                    if (pif.wb_halt) begin
                        next_state = HALTED;
                    end
                end
                HALTED: begin
                    next_state = HALTED;
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end
    end

    // Saturating debug counters; no increments are generated in HALTED.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles  <= '0;
            squash_events <= '0;
        end else begin
            if (stall_inc && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (squash_inc && (squash_events != '1)) begin
                squash_events <= squash_events + 1'b1;
            end
        end
    end

    assign halt = (state == HALTED);

    assign pif.pc_en       = pc_en;
    assign pif.ifid_en     = ifid_en;
    assign pif.idex_en     = idex_en;
    assign pif.exmem_en    = exmem_en;
    assign pif.memwb_en    = memwb_en;
    assign pif.ifid_flush  = ifid_flush;
    assign pif.idex_flush  = idex_flush;
    assign pif.exmem_flush = exmem_flush;
    assign pif.memwb_flush = memwb_flush;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl. Expected control vectors are
// queued when stimulus is driven and popped when the outputs are sampled.
module tb_pipeline_ctrl;

    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    //  ifid_flush, idex_flush, exmem_flush, memwb_flush}
    localparam logic [8:0] V_ZERO   = 9'b00000_0000;
    localparam logic [8:0] V_ALLEN  = 9'b11111_0000;
    localparam logic [8:0] V_LUSE   = 9'b00111_0100;
    localparam logic [8:0] V_DWAIT  = 9'b00001_0001;
    localparam logic [8:0] V_HALT   = 9'b01111_1110;
    localparam logic [8:0] V_BRANCH = 9'b11111_1100;
    localparam logic [8:0] V_JUMP   = 9'b11111_1000;
    localparam logic [8:0] V_MISS   = 9'b01111_1000;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          halt;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] squash_events;

    pipeline_ctrl_if pif();

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .pif           (pif.slave),
        .halt          (halt),
        .stall_cycles  (stall_cycles),
        .squash_events (squash_events)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 CLK = ~CLK;

    logic [8:0] sb[$];
    logic [8:0] exp_v;
    int checks     = 0;
    int failures   = 0;
    int exp_stall  = 0;
    int exp_squash = 0;

    function automatic logic [8:0] ctl_now();
        return {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
                pif.ifid_flush, pif.idex_flush, pif.exmem_flush, pif.memwb_flush};
    endfunction

    function automatic void bump_stall();
        if (exp_stall < MAX) exp_stall++;
    endfunction

    function automatic void bump_squash();
        if (exp_squash < MAX) exp_squash++;
    endfunction

    task automatic idle();
        pif.ihit            = 1'b1;
        pif.dhit            = 1'b0;
        pif.mem_dREN        = 1'b0;
        pif.mem_dWEN        = 1'b0;
        pif.mem_halt        = 1'b0;
        pif.wb_halt         = 1'b0;
        pif.ex_dREN         = 1'b0;
        pif.ex_wsel         = 5'd0;
        pif.id_rs           = 5'd0;
        pif.id_rt           = 5'd0;
        pif.ex_branch_taken = 1'b0;
        pif.id_jump         = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        @(negedge CLK);
        idle();
        pif.mem_dREN = 1'b1;
        sb.push_back(V_ZERO);
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL reset_ctl got=%b want=%b", ctl_now(), exp_v); end
        checks++;
        if (halt !== 1'b0 || stall_cycles !== '0 || squash_events !== '0) begin
            failures++; $display("[TB] FAIL reset_regs got halt=%b stall=%0d squash=%0d want 0/0/0", halt, stall_cycles, squash_events);
        end
        @(negedge CLK);
        idle();
        nRST = 1'b1;
        exp_stall = 0; exp_squash = 0;
        sb.push_back(V_ALLEN);
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL reset_run got=%b want=%b", ctl_now(), exp_v); end
    endtask

    task automatic test_load_use();
        @(negedge CLK);
        idle();
        pif.ex_dREN = 1'b1; pif.ex_wsel = 5'd2; pif.id_rs = 5'd2; pif.id_rt = 5'd5;
        sb.push_back(V_LUSE); bump_stall();
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL luse_rs got=%b want=%b", ctl_now(), exp_v); end
        @(negedge CLK);
        pif.ex_wsel = 5'd0; pif.id_rs = 5'd0; pif.id_rt = 5'd0;
        sb.push_back(V_ALLEN);
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL luse_r0 got=%b want=%b", ctl_now(), exp_v); end
        checks++;
        if (stall_cycles !== CW'(exp_stall)) begin failures++; $display("[TB] FAIL luse_stall got=%0d want=%0d", stall_cycles, exp_stall); end
        @(negedge CLK);
        pif.ex_wsel = 5'd7; pif.id_rs = 5'd3; pif.id_rt = 5'd7;
        sb.push_back(V_LUSE); bump_stall();
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL luse_rt got=%b want=%b", ctl_now(), exp_v); end
        @(negedge CLK);
        pif.ex_dREN = 1'b0;
        sb.push_back(V_ALLEN);
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL luse_noload got=%b want=%b", ctl_now(), exp_v); end
        checks++;
        if (stall_cycles !== CW'(exp_stall)) begin failures++; $display("[TB] FAIL luse_stall2 got=%0d want=%0d", stall_cycles, exp_stall); end
    endtask

    task automatic test_dwait();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            idle();
            pif.mem_dREN = 1'b1;
            sb.push_back(V_DWAIT); bump_stall();
            #1;
            exp_v = sb.pop_front(); checks++;
            if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL dwait_%0d got=%b want=%b", i, ctl_now(), exp_v); end
        end
        @(negedge CLK);
        pif.dhit = 1'b1;
        sb.push_back(V_ALLEN);
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL dwait_hit got=%b want=%b", ctl_now(), exp_v); end
        checks++;
        if (stall_cycles !== CW'(exp_stall)) begin failures++; $display("[TB] FAIL dwait_stall got=%0d want=%0d", stall_cycles, exp_stall); end
        @(negedge CLK);
        idle();
        pif.mem_dWEN = 1'b1; pif.ex_branch_taken = 1'b1;
        sb.push_back(V_DWAIT); bump_stall();
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL dwait_branch got=%b want=%b", ctl_now(), exp_v); end
        @(negedge CLK);
        pif.dhit = 1'b1;
        sb.push_back(V_BRANCH); bump_squash();
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL dwait_branch_hit got=%b want=%b", ctl_now(), exp_v); end
        @(negedge CLK);
        idle();
        #1;
        checks++;
        if (stall_cycles !== CW'(exp_stall) || squash_events !== CW'(exp_squash)) begin
            failures++; $display("[TB] FAIL dwait_counts got=%0d/%0d want=%0d/%0d", stall_cycles, squash_events, exp_stall, exp_squash);
        end
    endtask

    task automatic test_branch();
        @(negedge CLK);
        idle();
        pif.ex_branch_taken = 1'b1; pif.ihit = 1'b0;
        sb.push_back(V_BRANCH); bump_squash();
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL branch_miss got=%b want=%b", ctl_now(), exp_v); end
        @(negedge CLK);
        pif.ihit = 1'b1; pif.ex_dREN = 1'b1; pif.ex_wsel = 5'd4; pif.id_rs = 5'd4;
        sb.push_back(V_BRANCH); bump_squash();
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL branch_luse got=%b want=%b", ctl_now(), exp_v); end
        @(negedge CLK);
        idle();
        #1;
        checks++;
        if (stall_cycles !== CW'(exp_stall) || squash_events !== CW'(exp_squash)) begin
            failures++; $display("[TB] FAIL branch_counts got=%0d/%0d want=%0d/%0d", stall_cycles, squash_events, exp_stall, exp_squash);
        end
    endtask

    task automatic test_jump();
        @(negedge CLK);
        idle();
        pif.id_jump = 1'b1;
        sb.push_back(V_JUMP); bump_squash();
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL jump got=%b want=%b", ctl_now(), exp_v); end
        @(negedge CLK);
        pif.ihit = 1'b0;
        sb.push_back(V_JUMP); bump_squash();
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL jump_miss got=%b want=%b", ctl_now(), exp_v); end
        @(negedge CLK);
        pif.id_jump = 1'b0;
        sb.push_back(V_MISS); bump_stall();
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL imiss got=%b want=%b", ctl_now(), exp_v); end
        @(negedge CLK);
        idle();
        #1;
        checks++;
        if (stall_cycles !== CW'(exp_stall) || squash_events !== CW'(exp_squash)) begin
            failures++; $display("[TB] FAIL jump_counts got=%0d/%0d want=%0d/%0d", stall_cycles, squash_events, exp_stall, exp_squash);
        end
    endtask

    task automatic test_halt();
        @(negedge CLK);
        idle();
        pif.mem_halt = 1'b1; pif.mem_dREN = 1'b1; pif.dhit = 1'b1;
        sb.push_back(V_HALT);
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL halt_n got=%b want=%b", ctl_now(), exp_v); end
        @(negedge CLK);
        idle();
        pif.wb_halt = 1'b1;
        sb.push_back(V_HALT); bump_stall();
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL halt_drain got=%b want=%b", ctl_now(), exp_v); end
        checks++;
        if (halt !== 1'b0) begin failures++; $display("[TB] FAIL halt_early got=%b want=0", halt); end
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            idle();
            pif.ihit = 1'b0; pif.id_jump = 1'b1; pif.ex_branch_taken = 1'b1;
            pif.mem_dREN = 1'b1;
            sb.push_back(V_ZERO);
            #1;
            exp_v = sb.pop_front(); checks++;
            if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL halted_ctl_%0d got=%b want=%b", i, ctl_now(), exp_v); end
            checks++;
            if (halt !== 1'b1) begin failures++; $display("[TB] FAIL halted_flag_%0d got=%b want=1", i, halt); end
            checks++;
            if (stall_cycles !== CW'(exp_stall) || squash_events !== CW'(exp_squash)) begin
                failures++; $display("[TB] FAIL halted_counts_%0d got=%0d/%0d want=%0d/%0d", i, stall_cycles, squash_events, exp_stall, exp_squash);
            end
        end
    endtask

    task automatic test_reset_dwait();
        @(negedge CLK);
        idle();
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        exp_stall = 0; exp_squash = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            pif.mem_dREN = 1'b1; pif.dhit = 1'b0;
            sb.push_back(V_DWAIT); bump_stall();
            #1;
            exp_v = sb.pop_front(); checks++;
            if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL rdwait_%0d got=%b want=%b", i, ctl_now(), exp_v); end
        end
        #1;
        nRST = 1'b0;
        exp_stall = 0; exp_squash = 0;
        sb.push_back(V_ZERO);
        #1;
        exp_v = sb.pop_front(); checks++;
        if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL rdwait_inreset got=%b want=%b", ctl_now(), exp_v); end
        checks++;
        if (halt !== 1'b0 || stall_cycles !== '0 || squash_events !== '0) begin
            failures++; $display("[TB] FAIL rdwait_regs got halt=%b stall=%0d squash=%0d want 0/0/0", halt, stall_cycles, squash_events);
        end
        @(negedge CLK);
        idle();
        nRST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(V_ALLEN);
            #1;
            exp_v = sb.pop_front(); checks++;
            if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL rdwait_run_%0d got=%b want=%b", i, ctl_now(), exp_v); end
            checks++;
            if (stall_cycles !== CW'(exp_stall)) begin failures++; $display("[TB] FAIL rdwait_stall_%0d got=%0d want=%0d", i, stall_cycles, exp_stall); end
            @(negedge CLK);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            idle();
            if (i % 2 == 0) begin
                pif.ihit = 1'b0;
                sb.push_back(V_MISS); bump_stall();
            end else begin
                pif.id_jump = 1'b1;
                sb.push_back(V_JUMP); bump_squash();
            end
            #1;
            exp_v = sb.pop_front(); checks++;
            if (ctl_now() !== exp_v) begin failures++; $display("[TB] FAIL sat_ctl_%0d got=%b want=%b", i, ctl_now(), exp_v); end
        end
        @(negedge CLK);
        idle();
        #1;
        checks++;
        if (stall_cycles !== CW'(MAX) || squash_events !== CW'(MAX)) begin
            failures++; $display("[TB] FAIL sat_counts got=%0d/%0d want=%0d/%0d", stall_cycles, squash_events, MAX, MAX);
        end
    endtask

    initial begin
        nRST = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_dwait();
        test_branch();
        test_jump();
        test_halt();
        test_reset_dwait();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
